// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared constants and types for the custom 32-bit float format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

    localparam int BIAS   = 31;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b1111;
    localparam logic [3:0] ST_OVF     = 4'b0011;
    localparam logic [3:0] ST_UNF     = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } int2fp_state_t;

endpackage

`default_nettype wire

// File: rtl/fpu_int2fp.sv
// ============================================================================
// Module      : fpu_int2fp
// Description : Sequential int32 -> custom float converter, one normalising
//               left shift per cycle, truncating rounding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_int2fp
    import fpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    int2fp_state_t            r_state;
    int2fp_state_t            w_state_nxt;
    logic                     r_sign;
    logic [31:0]              r_mag;
    logic signed [EXP_W-1:0]  r_exp;
    logic                     r_done;
    logic [31:0]              r_data;
    logic [3:0]               r_status;

    logic [31:0]              w_abs;
    logic [EXP_W-1:0]         w_exp_biased;
    logic [MANT_W-1:0]        w_frac;
    logic                     w_inexact;
    logic                     w_zero;
    logic [31:0]              w_packed;
    logic [3:0]               w_status;

    // Two's-complement negate; 0x80000000 wraps to itself, which is the
    // correct unsigned magnitude.
    assign w_abs = int_in[31] ? (~int_in + 32'd1) : int_in;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (int_in == 32'd0) ? PACK : NORM;
                end
            end
            NORM: begin
                if (r_mag[31]) begin
                    w_state_nxt = PACK;
                end
            end
            PACK:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero operand reaches PACK with the MSB still clear.
    assign w_zero       = ~r_mag[31];
    assign w_exp_biased = EXP_W'(r_exp) + EXP_W'(BIAS);
    assign w_frac       = r_mag[30:6];
    assign w_inexact    = |r_mag[5:0];
    assign w_packed     = w_zero ? 32'd0 : {r_sign, w_exp_biased, w_frac};
    assign w_status     = (w_inexact && !w_zero) ? ST_INEXACT : ST_EXACT;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sign   <= 1'b0;
            r_mag    <= 32'd0;
            r_exp    <= '0;
            r_done   <= 1'b0;
            r_data   <= 32'd0;
            r_status <= 4'b0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= int_in[31];
                        r_mag  <= w_abs;
                        r_exp  <= EXP_W'(31);
                    end
                end
                NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= {r_mag[30:0], 1'b0};
                        r_exp <= r_exp - EXP_W'(1);
                    end
                end
                PACK: begin
                    r_data   <= w_packed;
                    r_status <= w_status;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = r_done;
    assign data_out   = r_data;
    assign status_out = r_status;

endmodule

`default_nettype wire

// File: tb/tb_fpu_int2fp.sv
// ============================================================================
// Module      : tb_fpu_int2fp
// Description : Directed self-checking bench for fpu_int2fp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_int2fp;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] int_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int n_checks = 0;
    int n_errors = 0;

    fpu_int2fp u_dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .int_in     (int_in),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .status_out (status_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called one step after a clock edge; the start request is sampled at the
    // following edge (E0). Latency counts edges after E0 until done is seen.
    task automatic convert(input string tag, input logic [31:0] val, input int lat,
                           input logic [31:0] exp_d, input logic [3:0] exp_s);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        start  = 1'b1;
        int_in = val;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!got && n < 40) begin
            n++;
            @(posedge clock); #1;
            if (done) got = 1'b1;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_stat"}, 32'(status_out), 32'(exp_s));
    endtask

    initial begin
        int n;
        int pulses;
        bit early;
        reset  = 1'b1;
        start  = 1'b0;
        int_in = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_stat", 32'(status_out), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        convert("pos1",   32'h0000_0001, 33, 32'h3E00_0000, 4'b0001);
        @(posedge clock); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("hold_data", data_out, 32'h3E00_0000);

        convert("neg3",   32'hFFFF_FFFD, 32, 32'hC100_0000, 4'b0001);
        convert("maxpos", 32'h7FFF_FFFF, 3,  32'h7BFF_FFFF, 4'b1111);
        convert("mid",    32'h1234_5678, 5,  32'h7646_8ACF, 4'b0001);
        convert("neg1",   32'hFFFF_FFFF, 33, 32'hBE00_0000, 4'b0001);
        convert("minneg", 32'h8000_0000, 2,  32'hFC00_0000, 4'b0001);
        // Issued during the done cycle of the previous conversion.
        convert("zero_b2b", 32'h0000_0000, 1, 32'h0000_0000, 4'b0001);
        @(posedge clock); #1;
        check("zero_idle", 32'(busy), 32'd0);
        check("zero_done", 32'(done), 32'd0);

        // Second start mid-conversion must be ignored.
        start  = 1'b1;
        int_in = 32'h0000_0001;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            n++;
            if (n == 5) begin
                start  = 1'b1;
                int_in = 32'h1234_5678;
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        check("ign_lat", 32'(n), 32'd33);
        check("ign_data", data_out, 32'h3E00_0000);
        check("ign_stat", 32'(status_out), 32'd1);

        // Reset at edge 10 of a fresh conversion aborts it.
        @(posedge clock); #1;
        start  = 1'b1;
        int_in = 32'h0000_0001;
        @(posedge clock); #1;
        start = 1'b0;
        early = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clock); #1;
            if (done) early = 1'b1;
        end
        check("abort_nodone_pre", 32'(early), 32'd0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_data", data_out, 32'd0);
        check("abort_stat", 32'(status_out), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done) pulses++;
        end
        check("abort_nodone_post", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
